// File: rtl/neander_io_pkg.sv
// ==== neander_io_pkg : status-bit indices and UART FSM states shared by TX and RX ====
// Rev 1.0
`default_nettype none

package neander_io_pkg;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_BUSY  = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_RX_FERR  = 5;
  localparam int ST_TX_OVF   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/neander_uart_rx.sv
// ==== neander_uart_rx : 8N1 receiver with synchronizer, holding register and sticky flags ====
// Rev 1.0
`default_nettype none

module neander_uart_rx
  import neander_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1;
  logic          sync2;
  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          armed;
  logic          done_ok;
  logic          done_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  always_comb begin
    done_ok  = (state == STOP) && (cnt == LAST) && sync2;
    done_bad = (state == STOP) && (cnt == LAST) && !sync2;
  end

  // armed blocks a held-low line (break or bad stop) from being seen as a new start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      armed   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sync2) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= sync2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            armed <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completing byte wins over a coincident read; a read still clears flags it does not set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (done_ok) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (rd) begin
        valid <= 1'b0;
      end

      if (done_ok && valid && !rd) begin
        overrun <= 1'b1;
      end else if (rd) begin
        overrun <= 1'b0;
      end

      if (done_bad) begin
        frame_err <= 1'b1;
      end else if (rd) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/neander_io_uart.sv
// ==== neander_io_uart : CPU I/O port peripheral - TX FIFO + 8N1 transmitter, RX via neander_uart_rx ====
// Rev 1.0
`default_nettype none

module neander_io_uart
  import neander_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] io_out,
  input  logic       io_write,
  input  logic       io_rd,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] io_in,
  output logic [7:0] io_status
);

  localparam int            AW   = $clog2(FIFO_DEPTH);
  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          tx_ovf;

  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end;

  logic          rx_valid;
  logic          rx_ovr;
  logic          rx_ferr;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  always_comb begin
    fifo_empty = (wptr == rptr);
    fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    bit_end    = (cnt == LAST);
    pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    push       = io_write && (!fifo_full || pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= io_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr   <= '0;
      rptr   <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (io_write && !push) begin
        tx_ovf <= 1'b1;
      end else if (io_rd) begin
        tx_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      uart_txd <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pop) begin
            shift    <= mem[rptr[AW-1:0]];
            uart_txd <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt      <= '0;
            bit_idx  <= 3'd0;
            uart_txd <= shift[0];
            shift    <= {1'b1, shift[7:1]};
            state    <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              uart_txd <= shift[0];
              shift    <= {1'b1, shift[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            // Back-to-back frames: next start bit follows the stop bit with no idle gap
            if (pop) begin
              shift    <= mem[rptr[AW-1:0]];
              uart_txd <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  neander_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (uart_rxd),
    .rd       (io_rd),
    .data     (io_in),
    .valid    (rx_valid),
    .overrun  (rx_ovr),
    .frame_err(rx_ferr)
  );

  always_comb begin
    io_status              = 8'h00;
    io_status[ST_RX_VALID] = rx_valid;
    io_status[ST_TX_FULL]  = fifo_full;
    io_status[ST_TX_EMPTY] = fifo_empty;
    io_status[ST_TX_BUSY]  = (state != IDLE);
    io_status[ST_RX_OVR]   = rx_ovr;
    io_status[ST_RX_FERR]  = rx_ferr;
    io_status[ST_TX_OVF]   = tx_ovf;
  end

endmodule

`default_nettype wire

// File: tb/tb_neander_io_uart.sv
// ==== tb_neander_io_uart : directed + randomized bench with a byte/frame-level reference model ====
// Rev 1.0
`default_nettype none

module tb_neander_io_uart;

  localparam int C = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] io_out;
  logic       io_write;
  logic       io_rd;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] io_in;
  logic [7:0] io_status;

  int vectors     = 0;
  int miscompares = 0;

  // Byte-level RX/flag model
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr, m_tovf;

  // Serial waveform capture and expectation
  logic cap_en = 1'b0;
  logic cap_txd[$];
  logic cap_busy[$];
  logic exp_txd[$];
  logic exp_busy[$];

  neander_io_uart #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io_out   (io_out),
    .io_write (io_write),
    .io_rd    (io_rd),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .io_in    (io_in),
    .io_status(io_status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_en) begin
      cap_txd.push_back(uart_txd);
      cap_busy.push_back(io_status[3]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] m_status();
    return {1'b0, m_tovf, m_ferr, m_ovr, 1'b0, 1'b1, 1'b0, m_valid};
  endfunction

  task automatic m_clear_rd();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_tovf  = 1'b0;
  endtask

  task automatic m_reset();
    m_clear_rd();
    m_data = 8'h00;
  endtask

  // Frame completion, optionally with a read in the same cycle
  task automatic m_rx(input logic [7:0] b, input logic stop_ok, input logic rd);
    if (stop_ok) begin
      if (rd) m_ovr = 1'b0;
      else if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
      if (rd) begin
        m_ferr = 1'b0;
        m_tovf = 1'b0;
      end
    end else begin
      m_ferr = 1'b1;
      if (rd) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_tovf  = 1'b0;
      end
    end
  endtask

  task automatic do_rd();
    io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
    m_clear_rd();
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(C);
    end
    uart_rxd = stop_bit;
    tick(C);
    uart_rxd = 1'b1;
  endtask

  task automatic start_cap();
    cap_txd.delete();
    cap_busy.delete();
    exp_txd.delete();
    exp_busy.delete();
    cap_en = 1'b1;
  endtask

  task automatic exp_idle(input int n);
    repeat (n) begin
      exp_txd.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic exp_frame(input logic [7:0] b);
    logic v;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) v = 1'b0;
      else if (i == 9) v = 1'b1;
      else v = b[i-1];
      repeat (C) begin
        exp_txd.push_back(v);
        exp_busy.push_back(1'b1);
      end
    end
  endtask

  task automatic check_cap(input string tag);
    logic ot, ob;
    cap_en = 1'b0;
    for (int i = 0; i < exp_txd.size(); i++) begin
      ot = (i < cap_txd.size()) ? cap_txd[i] : 1'bx;
      ob = (i < cap_busy.size()) ? cap_busy[i] : 1'bx;
      chk($sformatf("%s_txd[%0d]", tag, i), {7'b0, ot}, {7'b0, exp_txd[i]});
      chk($sformatf("%s_busy[%0d]", tag, i), {7'b0, ob}, {7'b0, exp_busy[i]});
    end
  endtask

  initial begin
    logic [7:0] b, b2;
    logic [7:0] bq[$];
    logic       stop_ok;
    int         mode;

    reset    = 1'b0;
    io_out   = 8'h00;
    io_write = 1'b0;
    io_rd    = 1'b0;
    uart_rxd = 1'b1;
    m_reset();
    tick(3);
    chk("reset_txd", {7'b0, uart_txd}, 8'h01);
    chk("reset_status", io_status, 8'h04);
    chk("reset_io_in", io_in, 8'h00);
    reset = 1'b1;
    tick(5);

    // Single byte 0xA5
    start_cap();
    io_out = 8'hA5; io_write = 1'b1;
    tick();
    io_write = 1'b0;
    chk("t1_empty_after_write", {7'b0, io_status[2]}, 8'h00);
    tick(48);
    exp_idle(2); exp_frame(8'hA5); exp_idle(6);
    check_cap("t1");
    chk("t1_status_end", io_status, m_status());

    // Overflow: one byte in flight, then FIFO_DEPTH+1 consecutive writes
    start_cap();
    b = 8'($urandom);
    io_out = b; io_write = 1'b1;
    tick();
    io_write = 1'b0;
    tick(2);
    bq.delete();
    for (int k = 1; k <= D + 1; k++) begin
      io_out = 8'(k); io_write = 1'b1;
      tick();
      if (bq.size() < D) bq.push_back(8'(k));
      else m_tovf = 1'b1;
    end
    io_write = 1'b0;
    chk("t2_status_full_ovf", io_status, 8'h4A);
    tick((D + 1) * 10 * C + 4);
    exp_idle(2);
    exp_frame(b);
    foreach (bq[k]) exp_frame(bq[k]);
    exp_idle(2);
    check_cap("t2");
    chk("t2_ovf_sticky", io_status, m_status());
    do_rd();
    chk("t2_after_rd", io_status, m_status());

    // Single RX byte, then read
    send_rx(8'h3C, 1'b1);
    tick(4);
    m_rx(8'h3C, 1'b1, 1'b0);
    chk("t3_io_in", io_in, m_data);
    chk("t3_status", io_status, m_status());
    do_rd();
    chk("t3_after_rd", io_status, 8'h04);

    // Read and write in the same cycle
    b = 8'($urandom);
    send_rx(b, 1'b1);
    tick(4);
    m_rx(b, 1'b1, 1'b0);
    io_out = 8'($urandom); io_write = 1'b1; io_rd = 1'b1;
    tick();
    io_write = 1'b0; io_rd = 1'b0;
    m_clear_rd();
    chk("rdwr_status", io_status, 8'h00);
    tick(10 * C + 4);
    chk("rdwr_done", io_status, m_status());

    // Overrun, then frame error
    send_rx(8'h11, 1'b1); tick(4); m_rx(8'h11, 1'b1, 1'b0);
    send_rx(8'h22, 1'b1); tick(4); m_rx(8'h22, 1'b1, 1'b0);
    chk("t4_io_in", io_in, 8'h22);
    chk("t4_overrun", io_status, m_status());
    b = 8'($urandom);
    send_rx(b, 1'b0); tick(4); m_rx(b, 1'b0, 1'b0);
    chk("t4_ferr_io_in", io_in, 8'h22);
    chk("t4_ferr_status", io_status, m_status());
    do_rd();

    // Glitch rejection, then read coincident with completion
    uart_rxd = 1'b0;
    tick();
    uart_rxd = 1'b1;
    tick(20);
    chk("t5_glitch", io_status, m_status());
    b = 8'($urandom);
    send_rx(b, 1'b1); tick(4); m_rx(b, 1'b1, 1'b0);
    b2 = 8'($urandom);
    send_rx(b2, 1'b1);
    io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
    m_rx(b2, 1'b1, 1'b1);
    chk("t5_coinc_io_in", io_in, m_data);
    chk("t5_coinc_status", io_status, m_status());
    tick(4);

    // Randomized RX traffic with random read placement
    for (int it = 0; it < 12; it++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(3) != 0);
      mode    = int'($urandom_range(2));
      send_rx(b, stop_ok);
      if (mode == 1) begin
        io_rd = 1'b1;
        tick();
        io_rd = 1'b0;
        m_rx(b, stop_ok, 1'b1);
        tick(4);
      end else begin
        tick(4);
        m_rx(b, stop_ok, 1'b0);
        if (mode == 2) do_rd();
      end
      chk($sformatf("rnd%0d_io_in", it), io_in, m_data);
      chk($sformatf("rnd%0d_status", it), io_status, m_status());
    end

    // Reset during data bit 3 of a TX frame
    b = 8'($urandom);
    send_rx(b, 1'b1); tick(4); m_rx(b, 1'b1, 1'b0);
    b2 = 8'($urandom);
    io_out = b2; io_write = 1'b1;
    tick();
    io_write = 1'b0;
    tick(18);
    chk("t6_bit3", {7'b0, uart_txd}, {7'b0, b2[3]});
    reset = 1'b0;
    #1;
    m_reset();
    chk("t6_txd", {7'b0, uart_txd}, 8'h01);
    chk("t6_status", io_status, 8'h04);
    chk("t6_io_in", io_in, m_data);
    tick(2);
    reset = 1'b1;
    tick(3);
    start_cap();
    b = 8'($urandom);
    io_out = b; io_write = 1'b1;
    tick();
    io_write = 1'b0;
    tick(48);
    exp_idle(2); exp_frame(b); exp_idle(6);
    check_cap("t6_fresh");
    chk("t6_final_status", io_status, m_status());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
